// File: rtl/sme_pkg.sv
// Shared types, character constants and the character compare for the string matcher.
// Build option: SME_NOCASE_EN folds ASCII upper case onto lower case in literal compares.
package sme_pkg;

   typedef enum logic [2:0] {IDLE, RD_STR, RD_PAT, SCAN, OUT} sme_state_t;

   localparam logic [7:0] CH_CARET  = 8'h5E;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_SPACE  = 8'h20;

   // Characters are zero-extended to this width before comparison.
   localparam int CMP_W = 32;

   function automatic logic char_eq(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b);
`ifdef SME_NOCASE_EN
      logic [CMP_W-1:0] fa;
      logic [CMP_W-1:0] fb;
      fa = a;
      fb = b;
      if (a >= 32'h41 && a <= 32'h5A) fa = a | 32'h20;
      if (b >= 32'h41 && b <= 32'h5A) fb = b | 32'h20;
      return fa == fb;
`else
      return a == b;
`endif
   endfunction

endpackage

// File: rtl/sme_cand_cmp.sv
// Combinational test of one candidate start position: body lanes in parallel plus
// the word-start and word-end anchor checks. Honours SME_NOCASE_EN through char_eq.
module sme_cand_cmp
   import sme_pkg::*;
#(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int CHAR_W  = 8,
   parameter int IDX_W   = $clog2(STR_MAX),
   parameter int SLW     = $clog2(STR_MAX + 1),
   parameter int PLW     = $clog2(PAT_MAX + 1)
) (
   input  logic [PAT_MAX+1:0][CHAR_W-1:0] win,
   input  logic [PAT_MAX-1:0][CHAR_W-1:0] body,
   input  logic [PLW-1:0]                 b,
   input  logic [SLW-1:0]                 str_len,
   input  logic [IDX_W-1:0]               i,
   input  logic                           anchor_s,
   input  logic                           anchor_e,
   output logic                           hit
);

   logic [PAT_MAX-1:0] lane_ok;
   logic [CHAR_W-1:0]  end_ch;
   logic               fit;
   logic               at_end;
   logic               start_ok;
   logic               end_ok;

   // win[0] is str[i-1]; win[k+1] is str[i+k]. Lanes past the body length always pass.
   always_comb begin
      end_ch = '0;
      for (int k = 0; k <= PAT_MAX; k++) begin
         if (k == int'(b)) end_ch = win[k+1];
      end
      for (int j = 0; j < PAT_MAX; j++) begin
         lane_ok[j] = (j >= int'(b)) || (body[j] == CHAR_W'(CH_DOT)) ||
                      char_eq(CMP_W'(body[j]), CMP_W'(win[j+1]));
      end
      fit      = (int'(i) + int'(b)) <= int'(str_len);
      at_end   = (int'(i) + int'(b)) == int'(str_len);
      start_ok = !anchor_s || (i == '0) || (win[0] == CHAR_W'(CH_SPACE));
      end_ok   = !anchor_e || at_end || (end_ch == CHAR_W'(CH_SPACE));
      hit      = fit && (&lane_ok) && start_ok && end_ok;
   end

endmodule

// File: rtl/sme_param.sv
// Parametrised string-matching engine: loads a string and patterns, then scans one
// candidate start per cycle and reports the first hit. Build option: SME_NOCASE_EN.
module sme_param
   import sme_pkg::*;
#(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int CHAR_W  = 8,
   parameter int IDX_W   = $clog2(STR_MAX)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CHAR_W-1:0] chardata,
   input  logic              isstring,
   input  logic              ispattern,
   output logic              valid,
   output logic              match,
   output logic [IDX_W-1:0]  match_index
);

   localparam int SLW = $clog2(STR_MAX + 1);
   localparam int PLW = $clog2(PAT_MAX + 1);
   localparam int PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

   logic [CHAR_W-1:0] str_q [STR_MAX];
   logic [CHAR_W-1:0] pat_q [PAT_MAX];

   sme_state_t     state_q, state_d;
   logic [SLW-1:0] str_len_q, str_len_d;
   logic [PLW-1:0] pat_len_q, pat_len_d;
   logic [IDX_W-1:0] i_q, i_d;
   logic           res_match_q, res_match_d;
   logic [IDX_W-1:0] res_idx_q, res_idx_d;
   logic           valid_q, valid_d;
   logic           match_q, match_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic             str_we, pat_we;
   logic [IDX_W-1:0] str_waddr;
   logic [PAW-1:0]   pat_waddr;

   logic                           anchor_s, anchor_e, hit;
   logic [PLW-1:0]                 b;
   logic [PAT_MAX-1:0][CHAR_W-1:0] body;
   logic [PAT_MAX+1:0][CHAR_W-1:0] win;

   always_comb begin
      anchor_s = (pat_len_q != '0) && (pat_q[0] == CHAR_W'(CH_CARET));
      anchor_e = (pat_len_q != '0) && (pat_q[PAW'(pat_len_q - PLW'(1))] == CHAR_W'(CH_DOLLAR));
      b        = pat_len_q - PLW'(anchor_s) - PLW'(anchor_e);
   end

   // Body is the pattern shifted past a leading caret; window reads outside the string give 0.
   always_comb begin
      for (int j = 0; j < PAT_MAX; j++) begin
         body[j] = '0;
         if (j + int'(anchor_s) < PAT_MAX) body[j] = pat_q[PAW'(j + int'(anchor_s))];
      end
      for (int k = 0; k < PAT_MAX + 2; k++) begin
         win[k] = '0;
         if ((int'(i_q) + k - 1 >= 0) && (int'(i_q) + k - 1 < STR_MAX))
            win[k] = str_q[IDX_W'(int'(i_q) + k - 1)];
      end
   end

   sme_cand_cmp #(
      .STR_MAX (STR_MAX),
      .PAT_MAX (PAT_MAX),
      .CHAR_W  (CHAR_W),
      .IDX_W   (IDX_W),
      .SLW     (SLW),
      .PLW     (PLW)
   ) u_cand_cmp (
      .win      (win),
      .body     (body),
      .b        (b),
      .str_len  (str_len_q),
      .i        (i_q),
      .anchor_s (anchor_s),
      .anchor_e (anchor_e),
      .hit      (hit)
   );

   always_comb begin
      state_d     = state_q;
      str_len_d   = str_len_q;
      pat_len_d   = pat_len_q;
      i_d         = i_q;
      res_match_d = res_match_q;
      res_idx_d   = res_idx_q;
      valid_d     = 1'b0;
      match_d     = 1'b0;
      idx_d       = '0;
      str_we      = 1'b0;
      str_waddr   = '0;
      pat_we      = 1'b0;
      pat_waddr   = '0;
      case (state_q)
         IDLE, RD_PAT: begin
            if (isstring) begin
               str_we    = 1'b1;
               str_len_d = SLW'(1);
               state_d   = RD_STR;
            end else if (ispattern && state_q == IDLE) begin
               pat_we    = 1'b1;
               pat_len_d = PLW'(1);
               state_d   = RD_PAT;
            end else if (ispattern) begin
               if (pat_len_q < PLW'(PAT_MAX)) begin
                  pat_we    = 1'b1;
                  pat_waddr = PAW'(pat_len_q);
                  pat_len_d = pat_len_q + PLW'(1);
               end
            end else if (state_q == RD_PAT) begin
               i_d     = '0;
               state_d = SCAN;
            end
         end
         RD_STR: begin
            if (isstring) begin
               if (str_len_q < SLW'(STR_MAX)) begin
                  str_we    = 1'b1;
                  str_waddr = IDX_W'(str_len_q);
                  str_len_d = str_len_q + SLW'(1);
               end
            end else if (ispattern) begin
               pat_we    = 1'b1;
               pat_len_d = PLW'(1);
               state_d   = RD_PAT;
            end
         end
         SCAN: begin
            if (str_len_q == '0) begin
               res_match_d = 1'b0;
               res_idx_d   = '0;
               state_d     = OUT;
            end else if (hit) begin
               res_match_d = 1'b1;
               res_idx_d   = i_q;
               state_d     = OUT;
            end else if (SLW'(i_q) == str_len_q - SLW'(1)) begin
               res_match_d = 1'b0;
               res_idx_d   = '0;
               state_d     = OUT;
            end else begin
               i_d = i_q + IDX_W'(1);
            end
         end
         OUT: begin
            valid_d = 1'b1;
            match_d = res_match_q;
            idx_d   = res_match_q ? res_idx_q : '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         str_len_q   <= '0;
         pat_len_q   <= '0;
         i_q         <= '0;
         res_match_q <= 1'b0;
         res_idx_q   <= '0;
         valid_q     <= 1'b0;
         match_q     <= 1'b0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         str_len_q   <= str_len_d;
         pat_len_q   <= pat_len_d;
         i_q         <= i_d;
         res_match_q <= res_match_d;
         res_idx_q   <= res_idx_d;
         valid_q     <= valid_d;
         match_q     <= match_d;
         idx_q       <= idx_d;
      end
   end

   // Character storage carries no reset; lengths alone decide what is live.
   always_ff @(posedge clk) begin
      if (str_we) str_q[str_waddr] <= chardata;
      if (pat_we) pat_q[pat_waddr] <= chardata;
   end

   assign valid       = valid_q;
   assign match       = match_q;
   assign match_index = idx_q;

endmodule

// File: tb/tb_sme_param.sv
// Scoreboard bench for sme_param: directed string/pattern vectors with hand-computed results.
module tb_sme_param;

   localparam int IDX_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic [7:0]       chardata;
   logic             isstring;
   logic             ispattern;
   logic             valid;
   logic             match;
   logic [IDX_W-1:0] match_index;

   typedef struct {
      string            name;
      logic             m;
      logic [IDX_W-1:0] idx;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   sme_param #(.STR_MAX(32), .PAT_MAX(8), .CHAR_W(8), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .chardata    (chardata),
      .isstring    (isstring),
      .ispattern   (ispattern),
      .valid       (valid),
      .match       (match),
      .match_index (match_index)
   );

   always #5 clk = ~clk;

   // Monitor: every valid pulse consumes one expected result.
   always @(negedge clk) begin
      if (reset === 1'b1 && valid === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: match=%0d index=%0d, required no result", match, match_index);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (match !== e.m || match_index !== e.idx) begin
               errors++;
               $display("FAIL %s: match=%0d index=%0d, required match=%0d index=%0d",
                        e.name, match, match_index, e.m, e.idx);
            end
         end
      end
   end

   task automatic check_out(input string name, input logic [IDX_W+1:0] act, input logic [IDX_W+1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic load_str(input string s);
      for (int k = 0; k < s.len(); k++) begin
         chardata  = s[k];
         isstring  = 1'b1;
         ispattern = 1'b0;
         @(posedge clk); #1;
      end
      isstring = 1'b0;
   endtask

   task automatic load_pat(input string s);
      for (int k = 0; k < s.len(); k++) begin
         chardata  = s[k];
         isstring  = 1'b0;
         ispattern = 1'b1;
         @(posedge clk); #1;
      end
      ispattern = 1'b0;
      chardata  = 8'h00;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no valid after %0d cycles, required one", name, n);
         q.delete();
      end
   endtask

   task automatic run(input string name, input string s, input string p,
                      input logic m, input logic [IDX_W-1:0] idx);
      exp_t e;
      if (s.len() != 0) load_str(s);
      e.name = name;
      e.m    = m;
      e.idx  = idx;
      q.push_back(e);
      load_pat(p);
      wait_drain(name);
   endtask

   initial begin
      string s32;
      string s40;
      reset     = 1'b0;
      isstring  = 1'b0;
      ispattern = 1'b0;
      chardata  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_out("rst_valid", {6'd0, valid}, 7'd0);
      check_out("rst_match", {6'd0, match}, 7'd0);
      check_out("rst_index", {2'd0, match_index}, 7'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      run("hello_wor",     "hello world", "wor",     1'b1, 5'd6);
      run("dot_o.w",       "",            "o.w",     1'b1, 5'd4);
      run("anchored_word", "",            "^wo.ld$", 1'b1, 5'd6);
      run("caret_orl",     "",            "^orl",    1'b0, 5'd0);
      run("abc_c$",        "abc",         "c$",      1'b1, 5'd2);
      run("abc_abcd",      "",            "abcd",    1'b0, 5'd0);

      s40 = {"abcdefghijklmnopqrstuvabcdef", "wxyz", "abcdefgh"};
      run("long_wxyz",     s40,           "wxyz",    1'b1, 5'd28);
      run("long_wxyz$",    "",            "wxyz$",   1'b1, 5'd28);

      // Abort a scan with reset: no result may appear.
      s32 = "abcdefghijklmnopqrstuvwxyzabcdef";
      load_str(s32);
      load_pat("zz");
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check_out("abort_valid", {6'd0, valid}, 7'd0);
      check_out("abort_match", {6'd0, match}, 7'd0);
      check_out("abort_index", {2'd0, match_index}, 7'd0);
      reset = 1'b1;
      repeat (40) @(posedge clk);
      #1;

      run("empty_str",     "",            "a",       1'b0, 5'd0);
      run("ab_b",          "ab",          "b",       1'b1, 5'd1);
      run("caret_dollar",  " x",          "^$",      1'b1, 5'd0);

      // isstring and ispattern together: the char must land in the string.
      chardata  = "z";
      isstring  = 1'b1;
      ispattern = 1'b1;
      @(posedge clk); #1;
      isstring  = 1'b0;
      ispattern = 1'b0;
      run("both_high",     "",            "z",       1'b1, 5'd0);

`ifdef SME_NOCASE_EN
      run("nocase_LL",     "Hello",       "LL",      1'b1, 5'd2);
`else
      run("case_LL",       "Hello",       "LL",      1'b0, 5'd0);
`endif

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
